// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
// Holds the digit count, the digit-index type, the scan state encoding and
// a helper that sizes the slot counter.
package display_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef logic [2:0] digit_idx_t;

  typedef enum logic {
    SHOW = 1'b0,
    DEAD = 1'b1
  } scan_state_t;

  // Bits needed to count 0..max(a,b)-1 (both arguments are >= 2 in use).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// scan_prescaler: slot counter for the display scanner.
// Latency: done is combinational from the count register (high in the tc cycle).
// Backpressure: none; counts every cycle, clr or rst return it to zero.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   clr   - synchronous clear, restarts the slot at zero
//   tc    - terminal count (last count value of the current slot)
//   done  - high while the count equals tc
module scan_prescaler #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] tc,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == tc);

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed anode scanner for an 8-digit display.
// Latency: sel/an/tick/frame_start registered together; digit_en reaches an in 1 cycle.
// Backpressure: none; free-running scan, slot timing never depends on inputs.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   digit_en    - per-digit enable, bit i shows digit i
//   sel         - index of the digit being scanned (digit mux select)
//   an          - active-low anode drive, at most one bit low
//   tick        - one-cycle pulse on every sel change
//   frame_start - one-cycle pulse when sel wraps to 0
//
// Build option: DISP_SCAN_DEADTIME_EN inserts a DEAD_CYCLES all-off guard
// between digits; without it sel advances straight after each SHOW slot.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
`ifdef DISP_SCAN_DEADTIME_EN
  , parameter int unsigned DEAD_CYCLES = 1000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       digit_en,
  output digit_idx_t       sel,
  output logic [7:0]       an,
  output logic             tick,
  output logic             frame_start
);

`ifdef DISP_SCAN_DEADTIME_EN
  localparam int unsigned CW = cnt_width(CLK_DIV, DEAD_CYCLES);
  localparam logic [CW-1:0] DEAD_TC = CW'(DEAD_CYCLES - 1);
`else
  localparam int unsigned CW = cnt_width(CLK_DIV, CLK_DIV);
`endif
  localparam logic [CW-1:0] SHOW_TC = CW'(CLK_DIV - 1);

  scan_state_t   state, next_state;
  digit_idx_t    next_sel;
  logic [7:0]    next_an;
  logic          slot_start;
  logic          done;
  logic [CW-1:0] tc;

  // Every state change starts a fresh count, so the counter is simply
  // cleared whenever it reaches its terminal count.
`ifdef DISP_SCAN_DEADTIME_EN
  assign tc = (state == DEAD) ? DEAD_TC : SHOW_TC;
`else
  assign tc = SHOW_TC;
`endif

  scan_prescaler #(
    .CW (CW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (done),
    .tc   (tc),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHOW;
      sel         <= '0;
      an          <= 8'hFF;
      tick        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= next_state;
      sel         <= next_sel;
      an          <= next_an;
      tick        <= slot_start;
      frame_start <= slot_start && (next_sel == '0);
    end
  end

  always_comb begin
    next_state = state;
    next_sel   = sel;
    slot_start = 1'b0;
    case (state)
      SHOW: begin
        if (done) begin
`ifdef DISP_SCAN_DEADTIME_EN
          next_state = DEAD;
`else
          next_sel   = digit_idx_t'(sel + 3'd1);
          slot_start = 1'b1;
`endif
        end
      end
`ifdef DISP_SCAN_DEADTIME_EN
      DEAD: begin
        if (done) begin
          next_state = SHOW;
          next_sel   = digit_idx_t'(sel + 3'd1);
          slot_start = 1'b1;
        end
      end
`endif
      default: next_state = SHOW;
    endcase

    // an is computed from the next state/sel so it lines up with them on
    // the same edge; digit_en is the value present in the current cycle.
    next_an = 8'hFF;
    if ((next_state == SHOW) && digit_en[next_sel]) begin
      next_an = ~(8'b1 << next_sel);
    end
  end

  a_an_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(~an));

`ifdef DISP_SCAN_DEADTIME_EN
  a_an_off_in_dead : assert property (@(posedge clk) disable iff (rst)
    (state == DEAD) |-> (an == 8'hFF));
`endif

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 100000: clock cycles per digit display slot; legal range 2..2^20.
REQ-002 Parameter DEAD_CYCLES, default 1000: clock cycles of all-anodes-off guard between digits; legal range 1..2^16.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 digit_en  input  8  per-digit enable; bit i high shows digit i.
REQ-006 sel  output  3  index of the digit currently scanned; drives the select of the 8-to-1 digit mux.
REQ-007 an  output  8  anode drive, active-low, at most one bit low.
REQ-008 tick  output  1  one-cycle pulse marking a sel change.
REQ-009 frame_start  output  1  one-cycle pulse when sel wraps to 0.

Function
REQ-010 The block SHALL implement two states, SHOW and DEAD, plus a slot counter wide enough for max(CLK_DIV, DEAD_CYCLES).
REQ-011 The block SHALL stay in SHOW for exactly CLK_DIV cycles and then go to DEAD with the counter cleared.
REQ-012 The block SHALL stay in DEAD for exactly DEAD_CYCLES cycles, then go to SHOW with sel = sel+1 modulo 8 and the counter cleared.
REQ-013 sel SHALL wrap from 7 to 0 and hold steady for the whole of SHOW and DEAD.
REQ-014 an SHALL be registered and SHALL be 8'hFF in DEAD.
REQ-015 In SHOW, an SHALL be ~(8'b1 << sel) when digit_en[sel] was high in the previous cycle, else 8'hFF.
REQ-016 A disabled digit SHALL still use its full slot, so the refresh period stays constant at 8*(CLK_DIV+DEAD_CYCLES).
REQ-017 sel, an, tick and frame_start SHALL update on the same edge so they agree in every cycle.
REQ-018 tick SHALL be high only in the first cycle of each SHOW slot after reset.
REQ-019 frame_start SHALL be high only in the cycles where tick is high and sel = 0.
REQ-020 A change on digit_en in mid-slot SHALL affect an one cycle later and SHALL NOT affect slot timing.

Reset
REQ-021 While rst is high: state = SHOW, counter = 0, sel = 0, an = 8'hFF, tick = 0, frame_start = 0.
REQ-022 The first edge after rst falls SHALL load the slot-0 SHOW value of an.
REQ-023 That first post-reset slot SHALL last CLK_DIV cycles counted from the reset release, with no tick or frame_start.
REQ-024 rst asserted in mid-slot, in either state, SHALL abort the slot and apply REQ-021 on the next edge.

Configuration
REQ-025 Macro DISP_SCAN_DEADTIME_EN SHALL control the dead-time guard.
REQ-026 With DISP_SCAN_DEADTIME_EN defined, the block SHALL behave as in REQ-010 to REQ-024.
REQ-027 Without DISP_SCAN_DEADTIME_EN, DEAD and DEAD_CYCLES SHALL be removed and sel SHALL advance directly after each CLK_DIV-cycle SHOW slot.
REQ-028 Without DISP_SCAN_DEADTIME_EN, the refresh period SHALL be 8*CLK_DIV.

Structure
REQ-029 The shared display package SHALL hold the NUM_DIGITS = 8 constant, the 3-bit digit-index type and the SHOW/DEAD state encoding.
REQ-030 The slot counter SHALL be one sub-module, scan_prescaler, with clk, rst, a clear input, a terminal-count input and a done pulse output.

Verification (CLK_DIV=4, DEAD_CYCLES=2, macro defined unless noted)
REQ-031 Reset release, digit_en=8'hFF -> an sequence FE,FE,FE,FF,FF, then FD for 4 cycles with tick=1 on the first; sel 0->1 in the same cycle.
REQ-032 Run 8 slots -> sel wraps 7->0 with tick=1 and frame_start=1 in the same cycle; frame_start is seen every 48 cycles.
REQ-033 digit_en=8'b0000_0100 -> an=FF except FB during the sel=2 SHOW cycles; slot period remains 6 cycles.
REQ-034 Assert rst for 1 cycle during the sel=5 DEAD phase -> next cycle sel=0, an=FF, tick=0; the next slot starts 4 cycles later.
REQ-035 Build without DISP_SCAN_DEADTIME_EN -> an never FF between enabled digits; sel advances every 4 cycles; frame_start every 32 cycles.
REQ-036 All runs -> assertion that an has at most one zero bit and that an=FF whenever state=DEAD.
